seq_detect_ctrl: RTL

//   Programmable serial-pattern detection controller: accepts a pattern configuration via a

---
 rtl/seq_detect_pkg.sv | 27 ++
 rtl/seq_shift_cmp.sv | 77 +++++++
 rtl/seq_detect_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
//   Shared types and helpers for the serial-pattern detection controller.
//   - state_e       : controller FSM states
//   - DEF_PAT_W     : default maximum pattern length
//   - DEF_CNT_W     : default match target / counter width
//   - len_mask_bit  : one bit of the pattern-length mask (bit idx is inside a
//                     pattern of length len). Callers build the full mask
//                     with a generate loop, so the mask width follows PAT_W.
// -----------------------------------------------------------------------------
package seq_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int unsigned DEF_PAT_W = 8;
  localparam int unsigned DEF_CNT_W = 8;

  function automatic logic len_mask_bit(input int unsigned len, input int unsigned idx);
    return (idx < len);
  endfunction

endpackage

// File: rtl/seq_shift_cmp.sv
// -----------------------------------------------------------------------------
// seq_shift_cmp
//   Serial history shift register, fill counter and masked pattern comparator.
//   hit_o is combinational: it compares the stored history plus the bit being
//   presented now, so a hit lands in the same cycle as the final pattern bit.
// Ports
//   clk     : clock
//   reset   : synchronous active-high reset
//   clr_i   : synchronous clear of history and fill (wins over shift_i)
//   shift_i : a qualified serial bit is present this cycle
//   din_i   : serial data bit
//   pat_i   : pattern, bit [len_i-1] first on the wire, bit 0 last
//   len_i   : pattern length (already clamped to 2..PAT_W)
//   ovl_i   : 1 = overlapping detection, 0 = restart fill after a hit
//   hit_o   : raw hit for this cycle
// -----------------------------------------------------------------------------
module seq_shift_cmp
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             din_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             ovl_i,
  output logic             hit_o
);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] mask;
  logic             enough;

  // Candidate window: history with the incoming bit appended at the LSB.
  assign cand = {hist_q[PAT_W-2:0], din_i};

  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
    assign mask[gi] = len_mask_bit(int'(len_i), gi);
  end

  // The current bit completes the window once len-1 bits are already held.
  assign enough = (fill_q >= (len_i - LEN_W'(1)));
  assign hit_o  = shift_i & enough & ((cand & mask) == (pat_i & mask));

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_i) begin
      hist_d = cand;
      if (hit_o && !ovl_i) begin
        fill_d = '0;
      end else if (fill_q < len_i) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl
//   Programmable serial-pattern detection controller. A pattern configuration
//   is accepted over a valid/ready handshake in IDLE, then start runs a
//   Mealy bit detector over the serial stream and counts matches until the
//   programmed target is reached (DONE). stop aborts to IDLE from anywhere.
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   cfg_valid/cfg_ready  : configuration handshake (ready only in IDLE)
//   cfg_pat, cfg_len     : pattern and its length (out-of-range len -> PAT_W)
//   cfg_ovl              : overlapping (1) / non-overlapping (0) detection
//   cfg_target           : matches required for DONE (0 behaves as 1)
//   start, stop          : run control; stop has priority over everything
//   din_valid, din       : serial input
//   busy, match, done    : RUN level, combinational match pulse, DONE level
//   match_cnt            : live saturating match counter, only present when
//                          SEQ_DET_MATCH_CNT_EN is defined
// -----------------------------------------------------------------------------
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [PAT_W-1:0]             cfg_pat,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  input  logic                         cfg_ovl,
  input  logic [CNT_W-1:0]             cfg_target,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         din_valid,
  input  logic                         din,
  output logic                         busy,
  output logic                         match,
  output logic                         done
`ifdef SEQ_DET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]             match_cnt
`endif
);

  localparam int unsigned LEN_W = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   target_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               cfg_fire;
  logic               run_clr;
  logic               shift_en;
  logic               hit;
  logic [LEN_W-1:0]   len_clamped;
  logic [CNT_W-1:0]   eff_target;
  logic [CNT_W:0]     cnt_inc;
  logic               reach;

  assign cfg_fire    = cfg_valid & (state_q == ST_IDLE) & ~stop;
  assign len_clamped = ((cfg_len < LEN_MIN) || (cfg_len > LEN_MAX)) ? LEN_MAX : cfg_len;

  // Clearing history/counters happens on every entry into RUN and on stop.
  assign run_clr  = stop | (start & ((state_q == ST_LOADED) | (state_q == ST_DONE)));
  assign shift_en = (state_q == ST_RUN) & din_valid;

  seq_shift_cmp #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_shift_cmp (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (run_clr),
    .shift_i (shift_en),
    .din_i   (din),
    .pat_i   (pat_q),
    .len_i   (len_q),
    .ovl_i   (ovl_q),
    .hit_o   (hit)
  );

  assign match = hit;

  // DONE is judged on the unsaturated increment so a target of all-ones
  // is still reachable.
  assign eff_target = (target_q == '0) ? CNT_W'(1) : target_q;
  assign cnt_inc    = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign reach      = (cnt_inc == {1'b0, eff_target});

  always_comb begin
    cnt_d = cnt_q;
    if (run_clr) begin
      cnt_d = '0;
    end else if (hit && !(&cnt_q)) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cfg_ready = (state_q == ST_IDLE);
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (cfg_valid)     state_d = ST_LOADED;
        ST_LOADED: if (start)         state_d = ST_RUN;
        ST_RUN:    if (hit && reach)  state_d = ST_DONE;
        ST_DONE:   if (start)         state_d = ST_RUN;
        default:                      state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pat_q    <= '0;
      len_q    <= LEN_MAX;
      ovl_q    <= 1'b0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cfg_fire) begin
        pat_q    <= cfg_pat;
        len_q    <= len_clamped;
        ovl_q    <= cfg_ovl;
        target_q <= cfg_target;
      end
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  assign match_cnt = cnt_q;
`endif

endmodule
